// File: rtl/led_seq_ctrl.sv
// Running-light sequencer for a 16-LED active-low bank: prescaled stepping with wrap/bounce/single-shot modes.
// Optional macro LED_SEQ_SPEED_EN adds a speed input that divides the step period by 1, 2, 4 or 8.
module led_seq_ctrl #(
    parameter int DIV   = 25000000,
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        hold,
    input  logic        dir,
    input  logic [1:0]  mode,
`ifdef LED_SEQ_SPEED_EN
    input  logic [1:0]  speed,
`endif
    output logic [15:0] out,
    output logic [3:0]  pos,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       pos_q, pos_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] term;
    logic             dir_q, dir_d;
    logic [1:0]       mode_q, mode_d;
    logic             done_q, done_d;
    logic             tick, at_end;
    logic [3:0]       fwd, rev;

`ifdef LED_SEQ_SPEED_EN
    logic [1:0]       speed_q, speed_d;

    assign term = (CNT_W'(DIV) >> speed_q) - CNT_W'(1);
`else
    assign term = CNT_W'(DIV - 1);
`endif

    assign tick   = (cnt_q == term);
    assign at_end = dir_q ? (pos_q == 4'd0) : (pos_q == 4'd15);
    assign fwd    = dir_q ? (pos_q - 4'd1) : (pos_q + 4'd1);
    assign rev    = dir_q ? (pos_q + 4'd1) : (pos_q - 4'd1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pos_q   <= 4'd0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            mode_q  <= 2'b00;
            done_q  <= 1'b0;
`ifdef LED_SEQ_SPEED_EN
            speed_q <= 2'b00;
`endif
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
`ifdef LED_SEQ_SPEED_EN
            speed_q <= speed_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
`ifdef LED_SEQ_SPEED_EN
        speed_d = speed_q;
`endif
        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d = RUN;
                    dir_d   = dir;
                    mode_d  = mode;
                    pos_d   = dir ? 4'd15 : 4'd0;
                    cnt_d   = '0;
`ifdef LED_SEQ_SPEED_EN
                    speed_d = speed;
`endif
                end
            end
            RUN, PAUSE: begin
                if (stop) begin
                    state_d = IDLE;
                    pos_d   = 4'd0;
                    cnt_d   = '0;
                end else if (hold) begin
                    // Counter is frozen, so a deferred tick fires on the release edge.
                    state_d = PAUSE;
                end else begin
                    state_d = RUN;
                    if (!tick) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        cnt_d = '0;
                        case (mode_q)
                            2'b01: begin
                                if (at_end) begin
                                    dir_d = ~dir_q;
                                    pos_d = rev;
                                end else begin
                                    pos_d = fwd;
                                end
                            end
                            2'b10: begin
                                if (at_end) begin
                                    state_d = IDLE;
                                    done_d  = 1'b1;
                                    pos_d   = 4'd0;
                                end else begin
                                    pos_d = fwd;
                                end
                            end
                            default: pos_d = fwd;
                        endcase
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign out  = (state_q == IDLE) ? 16'hFFFF : ~(16'h8000 >> pos_q);
    assign pos  = pos_q;
    assign busy = (state_q != IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Bench for led_seq_ctrl: step period 4 cycles (DIV=4, or DIV=8 with speed=1 when LED_SEQ_SPEED_EN is defined).
module tb_led_seq_ctrl;

`ifdef LED_SEQ_SPEED_EN
    localparam int TB_DIV = 8;
`else
    localparam int TB_DIV = 4;
`endif
    localparam int P = 4;

    logic        clk = 1'b0;
    logic        reset, start, stop, hold, dir;
    logic [1:0]  mode;
`ifdef LED_SEQ_SPEED_EN
    logic [1:0]  speed;
`endif
    logic [15:0] out;
    logic [3:0]  pos;
    logic        busy, done;

    led_seq_ctrl #(.DIV(TB_DIV), .CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .stop  (stop),
        .hold  (hold),
        .dir   (dir),
        .mode  (mode),
`ifdef LED_SEQ_SPEED_EN
        .speed (speed),
`endif
        .out   (out),
        .pos   (pos),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] o;
        logic [3:0]  p;
        logic        b;
        logic        d;
    } exp_t;

    typedef struct {
        logic       st, sp, hd, dr;
        logic [1:0] md;
        exp_t       e;
    } vec_t;

    exp_t sbq[$];
    vec_t tbl[$];
    int   n_chk = 0;
    int   n_pass = 0;

    function automatic exp_t mk(logic [15:0] o, logic [3:0] p, logic b, logic d);
        exp_t e;
        e.o = o; e.p = p; e.b = b; e.d = d;
        return e;
    endfunction

    function automatic exp_t idle_e(logic d);
        return mk(16'hFFFF, 4'd0, 1'b0, d);
    endfunction

    function automatic exp_t run_e(int p);
        logic [3:0] p4;
        p4 = 4'(p);
        return mk(~(16'h8000 >> p4), p4, 1'b1, 1'b0);
    endfunction

    function automatic vec_t v(logic st, logic sp, logic hd, logic dr, logic [1:0] md,
                               logic [15:0] o, logic [3:0] p, logic b, logic d);
        vec_t r;
        r.st = st; r.sp = sp; r.hd = hd; r.dr = dr; r.md = md;
        r.e = mk(o, p, b, d);
        return r;
    endfunction

    task automatic chk(input string nm, input exp_t act, input exp_t ex);
        n_chk++;
        if (act === ex) n_pass++;
        else $display("FAIL %s: got out=%h pos=%0d busy=%b done=%b, want out=%h pos=%0d busy=%b done=%b",
                      nm, act.o, act.p, act.b, act.d, ex.o, ex.p, ex.b, ex.d);
    endtask

    task automatic cyc(input string nm, input logic st, input logic sp, input logic hd,
                       input logic dr, input logic [1:0] md, input exp_t e);
        exp_t x;
        start = st; stop = sp; hold = hd; dir = dr; mode = md;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0; stop = 1'b0;
        x = sbq.pop_front();
        chk(nm, exp_t'({out, pos, busy, done}), x);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int j;
        reset = 1'b1; start = 1'b0; stop = 1'b0; hold = 1'b0; dir = 1'b0; mode = 2'b00;
`ifdef LED_SEQ_SPEED_EN
        speed = 2'd1;
`endif
        #2 reset = 1'b0;
        #1 chk("reset_async", exp_t'({out, pos, busy, done}), idle_e(1'b0));
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;

        // start/stop/hold control table, mode wrap
        tbl.push_back(v(0,0,0,0,2'd0, 16'hFFFF, 4'd0, 0, 0));
        tbl.push_back(v(0,1,0,0,2'd0, 16'hFFFF, 4'd0, 0, 0));
        tbl.push_back(v(1,1,0,0,2'd0, 16'hFFFF, 4'd0, 0, 0));
        tbl.push_back(v(1,0,0,0,2'd0, 16'h7FFF, 4'd0, 1, 0));
        tbl.push_back(v(0,0,0,0,2'd0, 16'h7FFF, 4'd0, 1, 0));
        tbl.push_back(v(0,0,0,0,2'd0, 16'h7FFF, 4'd0, 1, 0));
        tbl.push_back(v(0,0,1,0,2'd0, 16'h7FFF, 4'd0, 1, 0));
        tbl.push_back(v(0,0,1,0,2'd0, 16'h7FFF, 4'd0, 1, 0));
        tbl.push_back(v(1,0,1,0,2'd0, 16'h7FFF, 4'd0, 1, 0));
        tbl.push_back(v(1,0,0,0,2'd0, 16'h7FFF, 4'd0, 1, 0));
        tbl.push_back(v(0,0,0,0,2'd0, 16'hBFFF, 4'd1, 1, 0));
        tbl.push_back(v(0,0,0,1,2'd2, 16'hBFFF, 4'd1, 1, 0));
        tbl.push_back(v(0,0,0,1,2'd2, 16'hBFFF, 4'd1, 1, 0));
        tbl.push_back(v(0,0,0,1,2'd2, 16'hBFFF, 4'd1, 1, 0));
        tbl.push_back(v(0,0,0,1,2'd2, 16'hDFFF, 4'd2, 1, 0));
        tbl.push_back(v(0,0,0,0,2'd0, 16'hDFFF, 4'd2, 1, 0));
        tbl.push_back(v(0,0,0,0,2'd0, 16'hDFFF, 4'd2, 1, 0));
        tbl.push_back(v(0,0,0,0,2'd0, 16'hDFFF, 4'd2, 1, 0));
        tbl.push_back(v(0,0,1,0,2'd0, 16'hDFFF, 4'd2, 1, 0));
        tbl.push_back(v(0,0,0,0,2'd0, 16'hEFFF, 4'd3, 1, 0));
        tbl.push_back(v(1,1,0,0,2'd0, 16'hFFFF, 4'd0, 0, 0));
        tbl.push_back(v(0,0,0,0,2'd0, 16'hFFFF, 4'd0, 0, 0));
        for (int i = 0; i < tbl.size(); i++)
            cyc($sformatf("tbl[%0d]", i), tbl[i].st, tbl[i].sp, tbl[i].hd, tbl[i].dr, tbl[i].md, tbl[i].e);

        // wrap upward: 16 steps return to 7FFF
        cyc("wrap k=0", 1, 0, 0, 0, 2'd0, run_e(0));
`ifdef LED_SEQ_SPEED_EN
        speed = 2'd3;
`endif
        for (int k = 1; k <= 64; k++)
            cyc($sformatf("wrap k=%0d", k), 0, 0, 0, 0, 2'd0, run_e((k / P) % 16));
        cyc("wrap stop", 0, 1, 0, 0, 2'd0, idle_e(1'b0));
`ifdef LED_SEQ_SPEED_EN
        speed = 2'd1;
`endif

        // mode 11 behaves as wrap, downward through 0 -> 15
        cyc("wrap3dn k=0", 1, 0, 0, 1, 2'd3, run_e(15));
        for (int k = 1; k <= 68; k++)
            cyc($sformatf("wrap3dn k=%0d", k), 0, 0, 0, 0, 2'd0, run_e((15 - k / P + 32) % 16));
        cyc("wrap3dn stop", 0, 1, 0, 0, 2'd0, idle_e(1'b0));

        // bounce: 0..15,14..0,1 with no repeated end value
        cyc("bounce k=0", 1, 0, 0, 0, 2'd1, run_e(0));
        for (int k = 1; k < 32 * P; k++) begin
            j = k / P;
            cyc($sformatf("bounce k=%0d", k), 0, 0, 0, 0, 2'd0,
                run_e((j <= 15) ? j : ((j <= 30) ? 30 - j : j - 30)));
        end
        cyc("bounce stop", 0, 1, 0, 0, 2'd0, idle_e(1'b0));
        cyc("bounce idle", 0, 0, 0, 0, 2'd0, idle_e(1'b0));

        // single-shot downward: FFFE first, 7FFF last, then one done pulse
        cyc("shot k=0", 1, 0, 0, 1, 2'd2, mk(16'hFFFE, 4'd15, 1, 0));
        for (int k = 1; k < 16 * P; k++)
            cyc($sformatf("shot k=%0d", k), 0, 0, 0, 0, 2'd0, run_e(15 - k / P));
        cyc("shot done", 0, 0, 0, 0, 2'd0, idle_e(1'b1));
        cyc("shot done_low", 0, 0, 0, 0, 2'd0, idle_e(1'b0));
        cyc("shot idle", 0, 0, 0, 0, 2'd0, idle_e(1'b0));

        // hold for 10 cycles with cnt=2
        cyc("hold start", 1, 0, 0, 0, 2'd0, run_e(0));
        cyc("hold c1", 0, 0, 0, 0, 2'd0, run_e(0));
        cyc("hold c2", 0, 0, 0, 0, 2'd0, run_e(0));
        for (int k = 0; k < 10; k++)
            cyc($sformatf("hold h%0d", k), 0, 0, 1, 0, 2'd0, run_e(0));
        cyc("hold rel1", 0, 0, 0, 0, 2'd0, run_e(0));
        cyc("hold rel2", 0, 0, 0, 0, 2'd0, run_e(1));
        cyc("hold stop", 0, 1, 0, 0, 2'd0, idle_e(1'b0));

        // asynchronous reset mid-run
        cyc("rst start", 1, 0, 0, 0, 2'd0, run_e(0));
        for (int k = 1; k <= 5; k++)
            cyc($sformatf("rst run k=%0d", k), 0, 0, 0, 0, 2'd0, run_e(k / P));
        reset = 1'b0;
        #1 chk("rst mid_run", exp_t'({out, pos, busy, done}), idle_e(1'b0));
        @(posedge clk); #1;
        chk("rst held", exp_t'({out, pos, busy, done}), idle_e(1'b0));
        reset = 1'b1;
        for (int k = 0; k < 6; k++)
            cyc($sformatf("rst after k=%0d", k), 0, 0, 0, 0, 2'd0, idle_e(1'b0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/led_seq_ctrl.md
Name: led_seq_ctrl

Overview:
- Sequencing controller for the 16-LED active-low running-light display: owns the step-rate prescaler, run/pause/stop control and the pattern mode (wrap, bounce, single-shot).
- Drives the LED bank directly with one lit (low) bit at a time.
- Sits between the board push-button/switch inputs and the LED pins.

Parameters:
- DIV, 25000000, clock cycles per LED step (minimum 2; minimum 8 when LED_SEQ_SPEED_EN is defined).
- CNT_W, 32, prescaler counter width; must hold DIV-1.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle synchronous start pulse.
- stop  input  1  single-cycle synchronous stop pulse.
- hold  input  1  level; 1 pauses a running sequence.
- dir  input  1  0 = step pos upward (bit 15 toward bit 0); 1 = step pos downward.
- mode  input  2  00 wrap, 01 bounce, 10 single-shot, 11 treated as wrap.
- out  output  16  LED drive, active-low, at most one bit low.
- pos  output  4  current lit position; pos p drives out[15-p] low.
- busy  output  1  high in RUN or PAUSE.
- done  output  1  one-cycle pulse when a single-shot sequence completes.

Behaviour:
- Interface: one clock (clk). reset is asynchronous and active-low. Everything else is synchronous to posedge clk.
- Reset (reset=0, applied at any time including mid-run):
  - state=IDLE, pos=0, cnt=0, busy=0, done=0, out=16'hFFFF.
  - Internal dir/mode latches cleared to 0.
- States: IDLE, RUN, PAUSE. Encoding is free.
- out is a combinational decode of registered state: 16'hFFFF in IDLE; ~(16'h8000 >> pos) in RUN and PAUSE. busy = (state != IDLE).
- Priority per edge: stop > start > hold > tick.
- IDLE:
  - start=1 → RUN.
  - Latch dir and mode into dir_r and mode_r; mode/dir changes during a run are ignored.
  - pos = 0 if dir=0, else 15; cnt = 0.
  - out shows the first pattern in the cycle after the start edge.
- RUN:
  - cnt increments each cycle. Tick occurs when cnt == DIV-1; cnt then returns to 0. Step period is exactly DIV cycles, and the first step occurs DIV cycles after entry.
  - On a tick:
    - wrap: pos ± 1 modulo 16 (15→0 going up, 0→15 going down).
    - bounce: if at the end point in the current direction (15 going up, 0 going down), invert dir_r and move one step the other way, so no end value repeats. Otherwise pos ± 1.
    - single-shot: if at the end point → IDLE, done=1 for one cycle, pos=0, out=FFFF. Otherwise pos ± 1.
  - hold=1 → PAUSE; cnt frozen (not cleared); pos and out unchanged.
- PAUSE:
  - hold=0 → RUN; cnt resumes from its frozen value.
  - start is ignored in PAUSE and RUN.
- stop in RUN or PAUSE: → IDLE next edge, pos=0, cnt=0, out=FFFF. done is not pulsed. stop in IDLE has no effect.
- Simultaneous events:
  - start and stop together in IDLE: stay IDLE.
  - Tick and hold together: hold wins; the step is deferred; cnt stays at DIV-1 and the tick fires on the first RUN cycle after release.
- done is low at all times except its single completion cycle.

Optional Feature:
- Macro: LED_SEQ_SPEED_EN.
- Defined:
  - Adds input speed [1:0], latched at start alongside dir and mode.
  - Terminal count becomes (DIV >> speed) - 1, giving step periods of DIV, DIV/2, DIV/4, DIV/8 cycles.
  - speed changes during a run are ignored.
- Undefined:
  - No speed port.
  - Step period is always DIV.

Test Plan:
- Reset: hold reset=0 mid-run with DIV=4 → out=16'hFFFF, pos=0, busy=0, done=0 immediately (asynchronous); after release, state stays IDLE.
- Wrap up, DIV=4, mode=00, dir=0, start → next cycle out=16'h7FFF, busy=1; 4 cycles later out=16'hBFFF; after 16 steps out=16'h7FFF again.
- Bounce, DIV=4, mode=01, dir=0 → pos sequence 0,1,…,15,14,…,0,1, each end value appearing once per turn.
- Single-shot, DIV=4, mode=10, dir=1 → first out=16'hFFFE (pos 15); reaches pos 0, out=16'h7FFF; next tick done=1 for exactly one cycle, out=16'hFFFF, busy=0.
- Control, DIV=4, mode=00:
  - hold=1 for 10 cycles at cnt=2 → pos frozen; next step occurs 2 cycles after release.
  - stop and start asserted in the same cycle in RUN → IDLE, out=16'hFFFF, no done pulse.
- LED_SEQ_SPEED_EN defined, DIV=8, speed=2 latched at start → pos advances every 2 cycles; changing speed mid-run leaves the period unchanged.
